// File: rtl/tdm_demux_4ch.sv
// tdm_demux_4ch
// Receive-side TDM demultiplexer. A single serial stream carries four time
// slots of SLOT_W bits per frame, MSB first, with frame_sync marking bit 0 of
// slot 0. Each completed slot is latched into its own channel register and
// announced with a one-cycle ch_valid pulse. Framing violations pulse sync_err
// and either resynchronise in place or fall back to hunting for frame_sync.
module tdm_demux_4ch #(
    parameter int SLOT_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              din,
    input  logic              din_valid,
    input  logic              frame_sync,
    output logic [SLOT_W-1:0] ch0_data,
    output logic [SLOT_W-1:0] ch1_data,
    output logic [SLOT_W-1:0] ch2_data,
    output logic [SLOT_W-1:0] ch3_data,
    output logic [3:0]        ch_valid,
    output logic              frame_done,
    output logic              sync_err,
    output logic              locked,
    output logic [1:0]        cur_slot
);

    localparam int CNT_W = $clog2(SLOT_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SLOT_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    typedef enum logic {
        ST_HUNT   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    // State and datapath registers
    state_t            r_state;
    logic [SLOT_W-1:0] r_sh;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic [1:0]        r_slot;
    logic [SLOT_W-1:0] r_ch_data [4];
    logic [3:0]        r_ch_valid;
    logic              r_frame_done;
    logic              r_sync_err;
    logic              r_locked;

    // Next-state values from the decode process
    state_t            w_state_nxt;
    logic [SLOT_W-1:0] w_sh_nxt;
    logic [CNT_W-1:0]  w_bit_cnt_nxt;
    logic [1:0]        w_slot_nxt;
    logic [3:0]        w_ch_we;
    logic              w_frame_done_nxt;
    logic              w_sync_err_nxt;

    // Helpers: current bit appended to the shift register, or starting fresh
    logic              w_frame_start;
    logic [SLOT_W-1:0] w_word;
    logic [SLOT_W-1:0] w_first;

    assign w_frame_start = (r_bit_cnt == CNT_ZERO) && (r_slot == 2'd0);
    assign w_word        = {r_sh[SLOT_W-2:0], din};
    assign w_first       = {{(SLOT_W-1){1'b0}}, din};

    // State register: HUNT after reset, otherwise follows the decode process
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_HUNT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Framing decode: next state, counters, shift register and strobe requests
    always_comb begin
        w_state_nxt      = r_state;
        w_sh_nxt         = r_sh;
        w_bit_cnt_nxt    = r_bit_cnt;
        w_slot_nxt       = r_slot;
        w_ch_we          = 4'b0000;
        w_frame_done_nxt = 1'b0;
        w_sync_err_nxt   = 1'b0;

        if (din_valid) begin
            case (r_state)
                ST_HUNT: begin
                    if (frame_sync) begin
                        // Marker bit is bit 0 of slot 0
                        w_state_nxt   = ST_LOCKED;
                        w_sh_nxt      = w_first;
                        w_bit_cnt_nxt = CNT_ONE;
                        w_slot_nxt    = 2'd0;
                    end else begin
                        w_state_nxt = ST_HUNT;
                    end
                end
                ST_LOCKED: begin
                    if (w_frame_start) begin
                        if (frame_sync) begin
                            w_sh_nxt      = w_first;
                            w_bit_cnt_nxt = CNT_ONE;
                        end else begin
                            // Missing marker: lose lock and drop this bit
                            w_sync_err_nxt = 1'b1;
                            w_state_nxt    = ST_HUNT;
                            w_sh_nxt       = {SLOT_W{1'b0}};
                            w_bit_cnt_nxt  = CNT_ZERO;
                            w_slot_nxt     = 2'd0;
                        end
                    end else if (frame_sync) begin
                        // Unexpected marker: truncate the slot, restart the frame here
                        w_sync_err_nxt = 1'b1;
                        w_sh_nxt       = w_first;
                        w_bit_cnt_nxt  = CNT_ONE;
                        w_slot_nxt     = 2'd0;
                    end else if (r_bit_cnt == LAST_BIT) begin
                        w_ch_we[r_slot]  = 1'b1;
                        w_frame_done_nxt = (r_slot == 2'd3);
                        w_sh_nxt         = w_word;
                        w_bit_cnt_nxt    = CNT_ZERO;
                        w_slot_nxt       = r_slot + 2'd1;
                    end else begin
                        w_sh_nxt      = w_word;
                        w_bit_cnt_nxt = r_bit_cnt + CNT_ONE;
                    end
                end
                default: begin
                    w_state_nxt   = ST_HUNT;
                    w_sh_nxt      = {SLOT_W{1'b0}};
                    w_bit_cnt_nxt = CNT_ZERO;
                    w_slot_nxt    = 2'd0;
                end
            endcase
        end else begin
            // Idle cycle: hold everything, strobes fall back to 0
            w_state_nxt = r_state;
        end
    end

    // Shift register, position counters, strobes and lock indication
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sh         <= {SLOT_W{1'b0}};
            r_bit_cnt    <= CNT_ZERO;
            r_slot       <= 2'd0;
            r_ch_valid   <= 4'b0000;
            r_frame_done <= 1'b0;
            r_sync_err   <= 1'b0;
            r_locked     <= 1'b0;
        end else begin
            r_sh         <= w_sh_nxt;
            r_bit_cnt    <= w_bit_cnt_nxt;
            r_slot       <= w_slot_nxt;
            r_ch_valid   <= w_ch_we;
            r_frame_done <= w_frame_done_nxt;
            r_sync_err   <= w_sync_err_nxt;
            r_locked     <= (w_state_nxt == ST_LOCKED);
        end
    end

    // Channel registers: load the completed word into the slot's channel
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) begin
                r_ch_data[k] <= {SLOT_W{1'b0}};
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (w_ch_we[k]) begin
                    r_ch_data[k] <= w_word;
                end else begin
                    r_ch_data[k] <= r_ch_data[k];
                end
            end
        end
    end

    assign ch0_data   = r_ch_data[0];
    assign ch1_data   = r_ch_data[1];
    assign ch2_data   = r_ch_data[2];
    assign ch3_data   = r_ch_data[3];
    assign ch_valid   = r_ch_valid;
    assign frame_done = r_frame_done;
    assign sync_err   = r_sync_err;
    assign locked     = r_locked;
    assign cur_slot   = r_slot;

endmodule

// File: tb/tb_tdm_demux_4ch.sv
// Testbench for tdm_demux_4ch (SLOT_W=4). A frame-position reference model
// predicts every output after each clock edge.
module tb_tdm_demux_4ch;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         din;
    logic         din_valid;
    logic         frame_sync;
    logic [W-1:0] ch0_data;
    logic [W-1:0] ch1_data;
    logic [W-1:0] ch2_data;
    logic [W-1:0] ch3_data;
    logic [3:0]   ch_valid;
    logic         frame_done;
    logic         sync_err;
    logic         locked;
    logic [1:0]   cur_slot;

    int checks   = 0;
    int failures = 0;

    tdm_demux_4ch #(.SLOT_W(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .din_valid  (din_valid),
        .frame_sync (frame_sync),
        .ch0_data   (ch0_data),
        .ch1_data   (ch1_data),
        .ch2_data   (ch2_data),
        .ch3_data   (ch3_data),
        .ch_valid   (ch_valid),
        .frame_done (frame_done),
        .sync_err   (sync_err),
        .locked     (locked),
        .cur_slot   (cur_slot)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: position within the frame as a bit index 0..4W-1
    bit           m_locked;
    int           m_pos;
    int           m_word;
    logic [W-1:0] m_ch [4];
    logic [3:0]   e_cv;
    logic         e_fd;
    logic         e_se;

    typedef struct {
        logic d;
        logic v;
        logic fs;
    } stim_t;

    stim_t q[$];

    task automatic model_step(input logic d, input logic v, input logic fs, input logic r);
        int k;
        e_cv = 4'b0000;
        e_fd = 1'b0;
        e_se = 1'b0;
        if (!r) begin
            m_locked = 1'b0;
            m_pos    = 0;
            m_word   = 0;
            for (int i = 0; i < 4; i++) m_ch[i] = '0;
        end else if (v) begin
            if (!m_locked) begin
                if (fs) begin
                    m_locked = 1'b1;
                    m_pos    = 1;
                    m_word   = int'(d);
                end
            end else if (m_pos == 0) begin
                if (fs) begin
                    m_pos  = 1;
                    m_word = int'(d);
                end else begin
                    e_se     = 1'b1;
                    m_locked = 1'b0;
                end
            end else if (fs) begin
                e_se   = 1'b1;
                m_pos  = 1;
                m_word = int'(d);
            end else begin
                m_word = m_word * 2 + int'(d);
                m_pos  = m_pos + 1;
                if (m_pos % W == 0) begin
                    k       = m_pos / W - 1;
                    m_ch[k] = W'(m_word % (1 << W));
                    e_cv[k] = 1'b1;
                    e_fd    = (k == 3);
                    m_word  = 0;
                    if (m_pos == 4 * W) m_pos = 0;
                end
            end
        end
    endtask

    function automatic logic [24:0] exp_vec();
        logic [1:0] slot;
        slot = m_locked ? 2'((m_pos / W) % 4) : 2'd0;
        return {m_ch[3], m_ch[2], m_ch[1], m_ch[0], e_cv, e_fd, e_se, m_locked, slot};
    endfunction

    function automatic logic [24:0] obs_vec();
        return {ch3_data, ch2_data, ch1_data, ch0_data, ch_valid, frame_done, sync_err, locked, cur_slot};
    endfunction

    // Drive one cycle at the falling edge, update the model, settle after the rising edge
    task automatic drive(input logic d, input logic v, input logic fs, input logic r);
        @(negedge clk);
        din        = d;
        din_valid  = v;
        frame_sync = fs;
        rst_n      = r;
        model_step(d, v, fs, r);
        @(posedge clk);
        #1;
    endtask

    // Queue the first nbits of a frame; words = {w0,w1,w2,w3}; gap 0=none 1=alternate 2=random
    task automatic push_frame(input logic [15:0] words, input bit first_fs, input int gap,
                              input int inj, input int nbits);
        stim_t s;
        for (int i = 0; i < nbits; i++) begin
            s.d  = words[4 * W - 1 - i];
            s.v  = 1'b1;
            s.fs = (i == 0) ? first_fs : (i == inj);
            q.push_back(s);
            if (gap == 1 || (gap == 2 && $urandom_range(0, 3) == 0)) begin
                s.d  = 1'($urandom);
                s.v  = 1'b0;
                s.fs = 1'($urandom);
                q.push_back(s);
            end
        end
    endtask

    task automatic test_reset();
        stim_t s;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (obs_vec() !== 25'd0) begin
            failures++;
            $display("FAIL reset_initial got=%h want=%h", obs_vec(), 25'd0);
        end
        // Partial frame up to the middle of slot 2, then reset for 2 clocks
        push_frame(16'hA5C3, 1'b1, 0, -1, 2 * W + 2);
        while (q.size() > 0) begin
            s = q.pop_front();
            drive(s.d, s.v, s.fs, 1'b1);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL reset_prefix got=%h want=%h", obs_vec(), exp_vec());
            end
        end
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        checks++;
        if (obs_vec() !== 25'd0) begin
            failures++;
            $display("FAIL reset_midframe got=%h want=%h", obs_vec(), 25'd0);
        end
        push_frame(16'hA5C3, 1'b1, 0, -1, 4 * W);
        while (q.size() > 0) begin
            s = q.pop_front();
            drive(s.d, s.v, s.fs, 1'b1);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL reset_after got=%h want=%h", obs_vec(), exp_vec());
            end
        end
        checks++;
        if ({ch0_data, ch1_data, ch2_data, ch3_data} !== 16'hA5C3) begin
            failures++;
            $display("FAIL reset_after_data got=%h want=%h", {ch0_data, ch1_data, ch2_data, ch3_data}, 16'hA5C3);
        end
    endtask

    task automatic test_frame();
        stim_t s;
        int n_cv = 0;
        int n_fd = 0;
        push_frame(16'hA5C3, 1'b1, 0, -1, 4 * W);
        while (q.size() > 0) begin
            s = q.pop_front();
            drive(s.d, s.v, s.fs, 1'b1);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL frame got=%h want=%h", obs_vec(), exp_vec());
            end
            if (ch_valid != 4'b0000) n_cv++;
            if (frame_done) n_fd++;
        end
        checks++;
        if ({ch0_data, ch1_data, ch2_data, ch3_data} !== 16'hA5C3 || n_cv != 4 || n_fd != 1) begin
            failures++;
            $display("FAIL frame_totals got=%h cv=%0d fd=%0d want=a5c3 cv=4 fd=1",
                     {ch0_data, ch1_data, ch2_data, ch3_data}, n_cv, n_fd);
        end
    endtask

    task automatic test_gapped();
        stim_t s;
        int n_cv = 0;
        int n_fd = 0;
        push_frame(16'h3CA5, 1'b1, 0, -1, 4 * W);
        push_frame(16'hA5C3, 1'b1, 1, -1, 4 * W);
        while (q.size() > 0) begin
            s = q.pop_front();
            drive(s.d, s.v, s.fs, 1'b1);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL gapped got=%h want=%h", obs_vec(), exp_vec());
            end
            if (ch_valid != 4'b0000) n_cv++;
            if (frame_done) n_fd++;
        end
        checks++;
        if ({ch0_data, ch1_data, ch2_data, ch3_data} !== 16'hA5C3 || n_cv != 8 || n_fd != 2) begin
            failures++;
            $display("FAIL gapped_totals got=%h cv=%0d fd=%0d want=a5c3 cv=8 fd=2",
                     {ch0_data, ch1_data, ch2_data, ch3_data}, n_cv, n_fd);
        end
    endtask

    task automatic test_back_to_back();
        stim_t s;
        int n_cv = 0;
        int n_fd = 0;
        int n_se = 0;
        int exp_k = 0;
        push_frame(16'hA5C3, 1'b1, 0, -1, 4 * W);
        push_frame(16'h1248, 1'b1, 0, -1, 4 * W);
        while (q.size() > 0) begin
            s = q.pop_front();
            drive(s.d, s.v, s.fs, 1'b1);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL b2b got=%h want=%h", obs_vec(), exp_vec());
            end
            if (ch_valid != 4'b0000) begin
                n_cv++;
                checks++;
                if (ch_valid !== 4'(1 << exp_k)) begin
                    failures++;
                    $display("FAIL b2b_order got=%b want=%b", ch_valid, 4'(1 << exp_k));
                end
                exp_k = (exp_k + 1) % 4;
            end
            if (frame_done) n_fd++;
            if (sync_err) n_se++;
        end
        checks++;
        if ({ch0_data, ch1_data, ch2_data, ch3_data} !== 16'h1248 || n_cv != 8 || n_fd != 2 || n_se != 0) begin
            failures++;
            $display("FAIL b2b_totals got=%h cv=%0d fd=%0d se=%0d want=1248 cv=8 fd=2 se=0",
                     {ch0_data, ch1_data, ch2_data, ch3_data}, n_cv, n_fd, n_se);
        end
    endtask

    task automatic test_missing_sync();
        stim_t s;
        int n_se = 0;
        push_frame(16'hA5C3, 1'b1, 0, -1, 4 * W);
        push_frame(16'h1248, 1'b0, 0, -1, 4 * W);
        while (q.size() > 0) begin
            s = q.pop_front();
            drive(s.d, s.v, s.fs, 1'b1);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL nosync got=%h want=%h", obs_vec(), exp_vec());
            end
            if (sync_err) n_se++;
        end
        checks++;
        if (n_se != 1 || locked !== 1'b0 || ch0_data !== 4'hA || cur_slot !== 2'd0) begin
            failures++;
            $display("FAIL nosync_final got se=%0d locked=%b ch0=%h slot=%0d want se=1 locked=0 ch0=a slot=0",
                     n_se, locked, ch0_data, cur_slot);
        end
    endtask

    task automatic test_early_sync();
        stim_t s;
        // Slots 0,1 and bit 0 of slot 2, then a new frame whose marker lands on slot 2 bit 1
        push_frame(16'h76E1, 1'b1, 0, -1, 2 * W + 1);
        while (q.size() > 0) begin
            s = q.pop_front();
            drive(s.d, s.v, s.fs, 1'b1);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL early_prefix got=%h want=%h", obs_vec(), exp_vec());
            end
        end
        push_frame(16'h9BDF, 1'b1, 0, -1, 4 * W);
        s = q.pop_front();
        drive(s.d, s.v, s.fs, 1'b1);
        checks++;
        if (sync_err !== 1'b1 || cur_slot !== 2'd0 || ch2_data !== 4'hC || ch_valid !== 4'b0000 || locked !== 1'b1) begin
            failures++;
            $display("FAIL early_sync got se=%b slot=%0d ch2=%h cv=%b lk=%b want se=1 slot=0 ch2=c cv=0 lk=1",
                     sync_err, cur_slot, ch2_data, ch_valid, locked);
        end
        while (q.size() > 0) begin
            s = q.pop_front();
            drive(s.d, s.v, s.fs, 1'b1);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL early_rest got=%h want=%h", obs_vec(), exp_vec());
            end
        end
        checks++;
        if ({ch0_data, ch1_data, ch2_data, ch3_data} !== 16'h9BDF) begin
            failures++;
            $display("FAIL early_data got=%h want=9bdf", {ch0_data, ch1_data, ch2_data, ch3_data});
        end
    endtask

    task automatic test_random();
        stim_t s;
        int inj;
        bit ffs;
        for (int f = 0; f < 40; f++) begin
            inj = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 4 * W - 1)) : -1;
            ffs = ($urandom_range(0, 7) != 0);
            push_frame(16'($urandom), ffs, 2, inj, 4 * W);
        end
        while (q.size() > 0) begin
            s = q.pop_front();
            drive(s.d, s.v, s.fs, 1'b1);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL random got=%h want=%h", obs_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        din        = 1'b0;
        din_valid  = 1'b0;
        frame_sync = 1'b0;
        test_reset();
        test_frame();
        test_gapped();
        test_back_to_back();
        test_missing_sync();
        test_early_sync();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
